sd_rx_fifo_core: RTL and testbench
==================================

Name: sd_rx_fifo_core

Overview:
- Receive-side buffer between the SD card data serialiser and the DMA/Wishbone RX filler.
- Accepts 4-bit SD bus nibbles on each write strobe and packs 8 of them into a 32-bit word.
- Stores completed words in a circular word FIFO and presents the head word first-word-fall-through, so the filler can latch q in the same cycle it pulses rd.
- Single clock domain.

Parameters:
- BUS_W, 4, nibble width (matches SD_BUS_W); must divide 32.
- WORD_W, 32, output word width.
- DEPTH, 8, word FIFO depth; power of two, at least 2.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset); de-assertion must be synchronous to clk.
- d, input, BUS_W, nibble from the SD data serialiser.
- wr, input, 1, nibble write strobe, sampled each clk.
- q, output, WORD_W, head word of the FIFO (FWFT); value is don't-care while empty.
- rd, input, 1, pop the head word.
- full, output, 1, word FIFO holds DEPTH words.
- empty, output, 1, word FIFO holds 0 words.
- mem_empt, output, 1, empty AND no partial nibbles held in the packer.

Behaviour:
- Reset (rst=0, asynchronous):
  - Read and write pointers cleared; packer nibble counter and shift register cleared.
  - Outputs: full=0, empty=1, mem_empt=1, q=0.
- Packing:
  - On clk with wr=1 and full=0: shift_reg <= {shift_reg[WORD_W-BUS_W-1:0], d}, counter increments.
  - The first nibble of a word ends in q[31:28], the last in q[3:0] (SD MSB-first order).
  - On the 8th accepted nibble (counter wraps 7->0), the completed word {shift_reg[27:0], d} is written to mem[wptr] in the same edge and wptr increments.
  - A new word becomes visible on q with empty=0 the cycle after that edge.
- wr while full=1: the nibble is dropped; shift register and counter are unchanged. No overflow flag.
- Read:
  - q = mem[rptr] combinationally.
  - On clk with rd=1 and empty=0, rptr increments; the next word (if any) appears on q the following cycle.
  - rd while empty is ignored; pointers are unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - empty = (wptr == rptr).
  - full = (MSBs differ, remaining bits equal).
  - Both flags are combinational from the registered pointers.
- Simultaneous word commit and rd in the same cycle: both take effect, occupancy is unchanged. This is allowed only when not full, because wr is blocked while full.
- mem_empt = empty && (counter == 0).
- No internal throttling. The upstream serialiser must respect full, and the filler must respect empty.

Optional Feature:
- Macro SD_RX_FIFO_LEVEL_EN.
- When defined: extra output level [log2(DEPTH):0] = wptr - rptr, the number of complete words stored. It is 0 in reset and equals DEPTH when full.
- When undefined: the port and its logic are absent, with no other behavioural change.

Decomposition:
- Package sd_rx_fifo_pkg holds:
  - the BUS_W/WORD_W defaults;
  - NIBBLES_PER_WORD = WORD_W/BUS_W;
  - pointer-width function clog2(DEPTH)+1.
- One sub-module, sd_rx_nibble_packer. It takes clk, rst, d, wr_en (wr & ~full) and outputs word, word_valid (1-cycle pulse) and partial (counter != 0).
- The word FIFO (memory, pointers, flags) stays in the top level.

Test Plan:
- Reset: assert rst=0 mid-operation with 3 words stored -> immediately empty=1, full=0, mem_empt=1; after release a new 8-nibble burst produces exactly one word.
- Packing order: wr nibbles 1,2,3,4,5,6,7,8 -> after the 8th edge, empty=0 and q=32'h12345678; after 3 nibbles only, empty=1 and mem_empt=0.
- Fill to full: write 8 words (64 nibbles, word k = 32'hk0k0k0k0) -> full=1 after the 64th nibble. A 65th nibble with rd=0 is dropped; after one rd, 8 more nibbles produce a word that comes out after the original 8.
- FWFT drain: with 3 words stored, hold rd=1 for 4 cycles -> q shows words 0,1,2 on consecutive cycles, then empty=1. The 4th rd is ignored and a pointer underflow must not occur.
- Concurrent: with 2 words stored, complete a word on the same edge as rd -> occupancy stays 2, order preserved; with SD_RX_FIFO_LEVEL_EN, level=2 before and after.
- Wrap-around: stream 40 words through with random rd gaps, never exceeding DEPTH -> the output sequence matches the input sequence exactly, and full/empty are correct across pointer wrap.

Source files
------------

// File: rtl/sd_rx_fifo_pkg.sv
// Shared defaults and helpers for the SD receive FIFO slice.
// The optional level output is enabled by defining SD_RX_FIFO_LEVEL_EN.
package sd_rx_fifo_pkg;

  localparam int unsigned BUS_W_DEF        = 4;
  localparam int unsigned WORD_W_DEF       = 32;
  localparam int unsigned NIBBLES_PER_WORD = WORD_W_DEF / BUS_W_DEF;

  // Pointer width: one extra bit beyond the address distinguishes full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sd_rx_nibble_packer.sv
// Packs MSB-first SD bus nibbles into full words; word_valid marks the edge
// on which the final nibble of a word is accepted.
module sd_rx_nibble_packer
  import sd_rx_fifo_pkg::*;
#(
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  d,
  input  logic              wr_en,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              partial
);

  localparam int unsigned NPW = WORD_W / BUS_W;
  localparam int unsigned CW  = (NPW > 1) ? $clog2(NPW) : 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WORD_W-BUS_W-1:0] sr_q, sr_d;

  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    word_valid = 1'b0;
    word       = {sr_q, d};
    if (wr_en) begin
      sr_d = word[WORD_W-BUS_W-1:0];
      if (cnt_q == CW'(NPW - 1)) begin
        cnt_d      = '0;
        word_valid = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign partial = (cnt_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/sd_rx_fifo_core.sv
// SD receive buffer: nibble packer feeding a first-word-fall-through word FIFO.
// Defining SD_RX_FIFO_LEVEL_EN adds the level output (stored word count).
module sd_rx_fifo_core
  import sd_rx_fifo_pkg::*;
#(
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  d,
  input  logic              wr,
  output logic [WORD_W-1:0] q,
  input  logic              rd,
  output logic              full,
  output logic              empty,
  output logic              mem_empt
`ifdef SD_RX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  logic              wr_en;
  logic [WORD_W-1:0] pk_word;
  logic              pk_valid;
  logic              pk_partial;
  logic              pop;

  // Nibbles arriving while full never reach the packer, so it stays untouched.
  assign wr_en = wr & ~full;
  assign pop   = rd & ~empty;

  sd_rx_nibble_packer #(
    .BUS_W  (BUS_W),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .wr_en      (wr_en),
    .word       (pk_word),
    .word_valid (pk_valid),
    .partial    (pk_partial)
  );

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (pk_valid) begin
      mem_d[wptr_q[AW-1:0]] = pk_word;
      wptr_d                = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign q        = mem_q[rptr_q[AW-1:0]];
  assign mem_empt = empty & ~pk_partial;

`ifdef SD_RX_FIFO_LEVEL_EN
  assign level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_sd_rx_fifo_core.sv
// Scoreboard bench for sd_rx_fifo_core: stimulus pushes expected words,
// a monitor pops and compares q whenever a read is accepted.
module tb_sd_rx_fifo_core;

  logic        clk;
  logic        rst;
  logic [3:0]  d;
  logic        wr;
  logic [31:0] q;
  logic        rd;
  logic        full;
  logic        empty;
  logic        mem_empt;
`ifdef SD_RX_FIFO_LEVEL_EN
  logic [3:0]  level;
`endif

  int unsigned total;
  int unsigned bad;
  logic [31:0] sb[$];

  sd_rx_fifo_core #(
    .BUS_W  (4),
    .WORD_W (32),
    .DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .wr       (wr),
    .q        (q),
    .rd       (rd),
    .full     (full),
    .empty    (empty),
    .mem_empt (mem_empt)
`ifdef SD_RX_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs held from just after one edge until just after the next.
  task automatic cyc(input logic w, input logic [3:0] nb, input logic r);
    wr = w;
    d  = nb;
    rd = r;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input bit rd_last, input bit rnd_rd);
    logic r;
    int   guard;
    for (int i = 0; i < 8; i++) begin
      r = 1'b0;
      if (rnd_rd) begin
        guard = 0;
        while (full && guard < 20) begin
          cyc(1'b0, 4'h0, 1'b1);
          guard++;
        end
        r = ($urandom_range(0, 3) == 0);
      end
      if (i == 7 && rd_last) r = 1'b1;
      cyc(1'b1, w[31-4*i -: 4], r);
    end
    sb.push_back(w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!empty && n < 50) begin
      cyc(1'b0, 4'h0, 1'b1);
      n++;
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    d   = 4'h0;
    total = 0;
    bad   = 0;

    fork
      begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_mem_empt", {31'd0, mem_empt}, 32'd1);
        chk("rst_q", q, 32'h0);
`ifdef SD_RX_FIFO_LEVEL_EN
        chk("rst_level", {28'd0, level}, 32'd0);
`endif
        rst = 1'b1;

        // Packing order and partial-word visibility
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b1, 4'h3, 1'b0);
        chk("part_empty", {31'd0, empty}, 32'd1);
        chk("part_mem_empt", {31'd0, mem_empt}, 32'd0);
        for (int i = 4; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0);
        sb.push_back(32'h12345678);
        chk("pack_empty", {31'd0, empty}, 32'd0);
        chk("pack_q", q, 32'h12345678);
        cyc(1'b0, 4'h0, 1'b1);
        chk("pack_drained", {31'd0, empty}, 32'd1);
        chk("pack_mem_empt", {31'd0, mem_empt}, 32'd1);

        // Fill to full, dropped nibble, refill after one read
        for (int k = 0; k < 7; k++) put_word({4{4'(k), 4'h0}}, 1'b0, 1'b0);
        chk("fill7_full", {31'd0, full}, 32'd0);
        put_word({4{4'h7, 4'h0}}, 1'b0, 1'b0);
        chk("fill8_full", {31'd0, full}, 32'd1);
        chk("fill8_empty", {31'd0, empty}, 32'd0);
        cyc(1'b1, 4'hF, 1'b0);
        chk("drop_full", {31'd0, full}, 32'd1);
        cyc(1'b0, 4'h0, 1'b1);
        chk("pop1_full", {31'd0, full}, 32'd0);
        put_word(32'hABCDEF01, 1'b0, 1'b0);
        chk("refill_full", {31'd0, full}, 32'd1);
        drain();

        // FWFT drain with one extra read while empty
        put_word(32'h11111111, 1'b0, 1'b0);
        put_word(32'h22222222, 1'b0, 1'b0);
        put_word(32'h33333333, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1);
        chk("fwft_empty", {31'd0, empty}, 32'd1);
        chk("fwft_full", {31'd0, full}, 32'd0);
        put_word(32'h44444444, 1'b0, 1'b0);
        chk("noudf_empty", {31'd0, empty}, 32'd0);
        chk("noudf_full", {31'd0, full}, 32'd0);
        drain();

        // Word commit coinciding with a read
        put_word(32'hC0DE0001, 1'b0, 1'b0);
        put_word(32'hC0DE0002, 1'b0, 1'b0);
`ifdef SD_RX_FIFO_LEVEL_EN
        chk("conc_level_pre", {28'd0, level}, 32'd2);
`endif
        put_word(32'hC0DE0003, 1'b1, 1'b0);
`ifdef SD_RX_FIFO_LEVEL_EN
        chk("conc_level_post", {28'd0, level}, 32'd2);
`endif
        chk("conc_full", {31'd0, full}, 32'd0);
        cyc(1'b0, 4'h0, 1'b1);
        chk("conc_one_left", {31'd0, empty}, 32'd0);
        cyc(1'b0, 4'h0, 1'b1);
        chk("conc_empty", {31'd0, empty}, 32'd1);

        // Streaming across pointer wrap with random read gaps
        for (int k = 0; k < 40; k++) put_word($urandom, 1'b0, 1'b1);
        drain();
        chk("wrap_mem_empt", {31'd0, mem_empt}, 32'd1);
        chk("wrap_sb_left", sb.size(), 32'd0);

        // Asynchronous reset mid-operation
        put_word(32'h0A0A0A0A, 1'b0, 1'b0);
        put_word(32'h0B0B0B0B, 1'b0, 1'b0);
        put_word(32'h0C0C0C0C, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b0);
        cyc(1'b1, 4'h9, 1'b0);
        cyc(1'b1, 4'h9, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_full", {31'd0, full}, 32'd0);
        chk("arst_mem_empt", {31'd0, mem_empt}, 32'd1);
        chk("arst_q", q, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        put_word(32'h0F1E2D3C, 1'b0, 1'b0);
        chk("post_rst_word", {31'd0, empty}, 32'd0);
        cyc(1'b0, 4'h0, 1'b1);
        chk("post_rst_one", {31'd0, empty}, 32'd1);
        chk("post_rst_mem_empt", {31'd0, mem_empt}, 32'd1);
        chk("final_sb_left", sb.size(), 32'd0);
      end
      begin : monitor
        logic [31:0] exp;
        forever begin
          @(negedge clk);
          if (rst && rd && !empty) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_underrun: got %h expected none at %0t", q, $time);
            end else begin
              exp = sb.pop_front();
              chk("sb_q", q, exp);
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
